// File: rtl/ddr2_traffic_gen.sv
// rtl/ddr2_traffic_gen.sv - write/read-back pattern tester driving the DDR2 controller client port
module ddr2_traffic_gen #(
    parameter int unsigned N_WORDS   = 256,
    parameter logic [25:0] BASE_ADDR = 26'h0,
    parameter int unsigned ADDR_STEP = 4,
    parameter logic [31:0] SEED      = 32'hA5A5_0000,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [25:0] first_err_addr,
    output logic [63:0] first_err_data,
    output logic [25:0] c_addr,
    output logic [63:0] c_data_in,
    input  logic [63:0] c_data_out,
    input  logic        c_rdy,
    input  logic        c_ack,
    output logic        c_rd_req,
    output logic        c_wr_req
);
    localparam logic [15:0] LAST_IDX = 16'(N_WORDS - 1);
    localparam logic [15:0] WDOG_INIT = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, W_WAIT, W_REQ, W_HOLD, R_WAIT, R_REQ, R_HOLD, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] wdog_q, wdog_d;
    logic [25:0] c_addr_q, c_addr_d;
    logic [63:0] c_data_in_q, c_data_in_d;
    logic        c_wr_req_q, c_wr_req_d;
    logic        c_rd_req_q, c_rd_req_d;
    logic [15:0] err_count_q, err_count_d;
    logic [25:0] first_err_addr_q, first_err_addr_d;
    logic [63:0] first_err_data_q, first_err_data_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic        active;

    function automatic logic [63:0] pattern(input logic [15:0] idx);
        logic [31:0] x;
        x = {16'h0, idx} ^ SEED;
        return {x, ~x};
    endfunction

    function automatic logic [25:0] word_addr(input logic [15:0] idx);
        return BASE_ADDR + 26'(ADDR_STEP) * {10'h0, idx};
    endfunction

    assign active = (state_q != IDLE) && (state_q != DONE);

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        wdog_d           = wdog_q;
        c_addr_d         = c_addr_q;
        c_data_in_d      = c_data_in_q;
        c_wr_req_d       = c_wr_req_q;
        c_rd_req_d       = c_rd_req_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        done_d           = done_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d          = W_WAIT;
                    idx_d            = 16'h0;
                    err_count_d      = 16'h0;
                    first_err_addr_d = 26'h0;
                    first_err_data_d = 64'h0;
                    pass_d           = 1'b0;
                    timeout_d        = 1'b0;
                    done_d           = 1'b0;
                end
            end
            W_WAIT: begin
                if (c_rdy) begin
                    c_addr_d    = word_addr(idx_q);
                    c_data_in_d = pattern(idx_q);
                    c_wr_req_d  = 1'b1;
                    state_d     = W_REQ;
                end
            end
            W_REQ: begin
                if (c_ack) begin
                    c_wr_req_d = 1'b0;
                    state_d    = W_HOLD;
                end
            end
            // c_data_in stays put here: the controller samples it several cycles after c_ack
            W_HOLD: begin
                if (c_rdy) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 16'h0;
                        state_d = R_WAIT;
                    end else begin
                        idx_d   = idx_q + 16'h1;
                        state_d = W_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (c_rdy) begin
                    c_addr_d   = word_addr(idx_q);
                    c_rd_req_d = 1'b1;
                    state_d    = R_REQ;
                end
            end
            R_REQ: begin
                if (c_ack) begin
                    if (c_data_out != pattern(idx_q)) begin
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'h1;
                        if (err_count_q == 16'h0) begin
                            first_err_addr_d = c_addr_q;
                            first_err_data_d = c_data_out;
                        end
                    end
                    c_rd_req_d = 1'b0;
                    state_d    = R_HOLD;
                end
            end
            R_HOLD: begin
                if (c_rdy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_count_q == 16'h0) && !timeout_q;
                    end else begin
                        idx_d   = idx_q + 16'h1;
                        state_d = R_WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog expiry only matters when the state is not already advancing
        if (active && (state_d == state_q) && (wdog_q <= 16'h1)) begin
            state_d    = DONE;
            c_wr_req_d = 1'b0;
            c_rd_req_d = 1'b0;
            timeout_d  = 1'b1;
            done_d     = 1'b1;
            pass_d     = 1'b0;
        end

        if (state_d != state_q) wdog_d = WDOG_INIT;
        else if (active)        wdog_d = wdog_q - 16'h1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            idx_q            <= 16'h0;
            wdog_q           <= 16'h0;
            c_addr_q         <= 26'h0;
            c_data_in_q      <= 64'h0;
            c_wr_req_q       <= 1'b0;
            c_rd_req_q       <= 1'b0;
            err_count_q      <= 16'h0;
            first_err_addr_q <= 26'h0;
            first_err_data_q <= 64'h0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            wdog_q           <= wdog_d;
            c_addr_q         <= c_addr_d;
            c_data_in_q      <= c_data_in_d;
            c_wr_req_q       <= c_wr_req_d;
            c_rd_req_q       <= c_rd_req_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
        end
    end

    assign busy           = active;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
    assign c_addr         = c_addr_q;
    assign c_data_in      = c_data_in_q;
    assign c_wr_req       = c_wr_req_q;
    assign c_rd_req       = c_rd_req_q;
endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// tb/tb_ddr2_traffic_gen.sv - randomized bench with a behavioural DDR2 controller model
module tb_ddr2_traffic_gen;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic clk, rst_n, start_a, start_b, sel;
    logic c_rdy, c_ack;
    logic [63:0] c_data_out;

    logic a_busy, a_done, a_pass, a_timeout, a_rd, a_wr;
    logic [15:0] a_err;
    logic [25:0] a_feaddr, a_addr;
    logic [63:0] a_fedata, a_din;
    logic b_busy, b_done, b_pass, b_timeout, b_rd, b_wr;
    logic [15:0] b_err;
    logic [25:0] b_feaddr, b_addr;
    logic [63:0] b_fedata, b_din;

    logic m_wr, m_rd;
    logic [25:0] m_addr;
    logic [63:0] m_din;
    logic [201:0] a_all;

    int n_checks, n_errors;
    int force_lat = -1;
    bit no_ack = 1'b0;
    int hold_viol = 0;
    int excl_viol = 0;
    int rd_cnt = 0;
    logic [63:0] mem [logic [25:0]];
    logic [63:0] corrupt [logic [25:0]];
    logic [25:0] log_addr[$];
    logic [63:0] log_data[$];

    assign m_wr   = sel ? b_wr : a_wr;
    assign m_rd   = sel ? b_rd : a_rd;
    assign m_addr = sel ? b_addr : a_addr;
    assign m_din  = sel ? b_din : a_din;
    assign a_all  = {a_busy, a_done, a_pass, a_timeout, a_err, a_feaddr, a_fedata,
                     a_addr, a_din, a_rd, a_wr};

    ddr2_traffic_gen #(.N_WORDS(4), .BASE_ADDR(26'h0), .ADDR_STEP(4), .SEED(SEED), .TIMEOUT(64)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(a_busy), .done(a_done), .pass(a_pass),
        .timeout(a_timeout), .err_count(a_err), .first_err_addr(a_feaddr), .first_err_data(a_fedata),
        .c_addr(a_addr), .c_data_in(a_din), .c_data_out(c_data_out), .c_rdy(sel ? 1'b0 : c_rdy),
        .c_ack(sel ? 1'b0 : c_ack), .c_rd_req(a_rd), .c_wr_req(a_wr));

    ddr2_traffic_gen #(.N_WORDS(2), .BASE_ADDR(26'h3FFFFFC), .ADDR_STEP(4), .SEED(SEED), .TIMEOUT(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done), .pass(b_pass),
        .timeout(b_timeout), .err_count(b_err), .first_err_addr(b_feaddr), .first_err_data(b_fedata),
        .c_addr(b_addr), .c_data_in(b_din), .c_data_out(c_data_out), .c_rdy(sel ? c_rdy : 1'b0),
        .c_ack(sel ? c_ack : 1'b0), .c_rd_req(b_rd), .c_wr_req(b_wr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if ((a_wr && a_rd) || (b_wr && b_rd)) excl_viol++;

    function automatic logic [63:0] pat(input int i);
        logic [31:0] x;
        x = {16'h0, 16'(i)} ^ SEED;
        return {x, ~x};
    endfunction

    function automatic logic [25:0] exp_addr(input logic [25:0] base, input int i);
        logic [25:0] r;
        r = base + 26'(i * 4);
        return r;
    endfunction

    // Controller: accept a request, go busy, ack after a latency, sample write data 3 cycles later
    initial begin : ctrl_model
        int lat, k;
        bit is_wr;
        logic [25:0] ma;
        logic [63:0] md;
        c_rdy = 1'b1; c_ack = 1'b0; c_data_out = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                c_rdy = 1'b1; c_ack = 1'b0;
            end else if (m_wr || m_rd) begin
                is_wr = m_wr; ma = m_addr; md = m_din;
                c_rdy = 1'b0;
                lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
                force_lat = -1;
                k = 0;
                while (k < lat && rst_n) begin
                    @(negedge clk);
                    k++;
                    if (rst_n && !(is_wr ? (m_wr === 1'b1 && m_din === md && m_addr === ma)
                                         : (m_rd === 1'b1 && m_addr === ma)))
                        hold_viol++;
                end
                if (!rst_n) begin
                    c_rdy = 1'b1;
                end else if (no_ack) begin
                    k = 0;
                    while ((m_wr || m_rd) && k < 200) begin @(negedge clk); k++; end
                    c_rdy = 1'b1;
                end else begin
                    if (!is_wr) begin
                        c_data_out = (mem.exists(ma) ? mem[ma] : 64'h0) ^
                                     (corrupt.exists(ma) ? corrupt[ma] : 64'h0);
                        rd_cnt++;
                    end
                    c_ack = 1'b1;
                    @(negedge clk);
                    c_ack = 1'b0;
                    if (is_wr) begin
                        repeat (3) @(negedge clk);
                        if (m_din !== md) hold_viol++;
                        mem[ma] = md;
                        log_addr.push_back(ma);
                        log_data.push_back(md);
                    end
                    c_rdy = 1'b1;
                end
            end
        end
    end

    task automatic pulse_start(input bit use_b);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk); #1;
            if (use_b ? b_done : a_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic clear_logs();
        log_addr.delete(); log_data.delete(); rd_cnt = 0; hold_viol = 0; excl_viol = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (a_all !== '0) begin n_errors++; $display("FAIL reset_a: got %h expected 0", a_all); end
        n_checks++; if ({b_busy, b_done, b_pass, b_timeout, b_err, b_addr, b_din, b_rd, b_wr} !== '0) begin
            n_errors++; $display("FAIL reset_b: outputs not all 0 (busy=%b addr=%h)", b_busy, b_addr); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clean_pass();
        bit ok;
        sel = 1'b0; corrupt.delete(); clear_logs();
        pulse_start(1'b0);
        n_checks++; if (a_busy !== 1'b1) begin n_errors++; $display("FAIL clean_busy: got %b expected 1", a_busy); end
        wait_done(1'b0, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL clean_done: got 0 expected 1 within budget"); end
        n_checks++; if (log_addr.size() != 4) begin n_errors++; $display("FAIL clean_nwr: got %0d expected 4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            n_checks++; if (log_addr[i] !== exp_addr(26'h0, i)) begin
                n_errors++; $display("FAIL clean_addr%0d: got %h expected %h", i, log_addr[i], exp_addr(26'h0, i)); end
            n_checks++; if (log_data[i] !== pat(i)) begin
                n_errors++; $display("FAIL clean_data%0d: got %h expected %h", i, log_data[i], pat(i)); end
        end
        n_checks++; if (rd_cnt != 4) begin n_errors++; $display("FAIL clean_nrd: got %0d expected 4", rd_cnt); end
        n_checks++; if ({a_pass, a_timeout, a_busy, a_err} !== {3'b100, 16'h0}) begin
            n_errors++; $display("FAIL clean_status: got pass=%b to=%b busy=%b err=%0d expected 1 0 0 0",
                                 a_pass, a_timeout, a_busy, a_err); end
        n_checks++; if (excl_viol != 0) begin n_errors++; $display("FAIL clean_excl: got %0d expected 0", excl_viol); end
    endtask

    task automatic test_single_corrupt();
        bit ok;
        logic [63:0] exp_data;
        sel = 1'b0; corrupt.delete(); clear_logs();
        corrupt[26'd8] = 64'h1;
        exp_data = pat(2) ^ 64'h1;
        pulse_start(1'b0);
        wait_done(1'b0, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL corrupt_done: got 0 expected 1"); end
        n_checks++; if (a_err !== 16'd1) begin n_errors++; $display("FAIL corrupt_cnt: got %0d expected 1", a_err); end
        n_checks++; if (a_feaddr !== 26'd8) begin n_errors++; $display("FAIL corrupt_addr: got %h expected 8", a_feaddr); end
        n_checks++; if (a_fedata !== exp_data) begin
            n_errors++; $display("FAIL corrupt_data: got %h expected %h", a_fedata, exp_data); end
        n_checks++; if (a_pass !== 1'b0) begin n_errors++; $display("FAIL corrupt_pass: got %b expected 0", a_pass); end
        corrupt.delete();
    endtask

    task automatic test_random_corrupt();
        bit ok;
        int exp_cnt, first;
        logic [63:0] m;
        for (int it = 0; it < 4; it++) begin
            sel = 1'b0; corrupt.delete(); clear_logs();
            exp_cnt = 0; first = -1;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    m = 64'h1 << $urandom_range(0, 63);
                    corrupt[exp_addr(26'h0, i)] = m;
                    exp_cnt++;
                    if (first < 0) first = i;
                end
            end
            pulse_start(1'b0);
            wait_done(1'b0, ok);
            n_checks++; if (!ok || a_err !== 16'(exp_cnt)) begin
                n_errors++; $display("FAIL rnd_cnt%0d: got %0d expected %0d", it, a_err, exp_cnt); end
            n_checks++; if (a_pass !== (exp_cnt == 0)) begin
                n_errors++; $display("FAIL rnd_pass%0d: got %b expected %b", it, a_pass, exp_cnt == 0); end
            if (first >= 0) begin
                n_checks++; if (a_feaddr !== exp_addr(26'h0, first) ||
                                a_fedata !== (pat(first) ^ corrupt[exp_addr(26'h0, first)])) begin
                    n_errors++; $display("FAIL rnd_first%0d: got %h/%h expected word %0d", it, a_feaddr, a_fedata, first); end
            end
        end
        corrupt.delete();
    endtask

    task automatic test_refresh();
        bit ok;
        sel = 1'b0; corrupt.delete(); clear_logs();
        force_lat = 20;
        pulse_start(1'b0);
        wait_done(1'b0, ok);
        n_checks++; if (!ok || a_pass !== 1'b1) begin n_errors++; $display("FAIL refresh_pass: got %b expected 1", a_pass); end
        n_checks++; if (hold_viol != 0) begin n_errors++; $display("FAIL refresh_hold: got %0d expected 0", hold_viol); end
        n_checks++; if (log_data.size() < 1 || log_data[0] !== 64'hA5A50000_5A5AFFFF) begin
            n_errors++; $display("FAIL refresh_data0: got %0d writes expected first A5A500005A5AFFFF", log_data.size()); end
    endtask

    task automatic test_timeout();
        int k;
        sel = 1'b1; clear_logs(); no_ack = 1'b1;
        pulse_start(1'b1);
        k = 0;
        while (!b_wr && k < 50) begin @(posedge clk); #1; k++; end
        n_checks++; if (b_wr !== 1'b1) begin n_errors++; $display("FAIL to_req: got %b expected 1", b_wr); end
        k = 0;
        while ((b_wr || b_rd) && k < 40) begin @(posedge clk); #1; k++; end
        n_checks++; if (k < 14 || k > 17) begin n_errors++; $display("FAIL to_cycles: got %0d expected 14..17", k); end
        n_checks++; if ({b_done, b_timeout, b_pass, b_busy} !== 4'b1100) begin
            n_errors++; $display("FAIL to_status: got done/to/pass/busy=%b expected 1100", {b_done, b_timeout, b_pass, b_busy}); end
        no_ack = 1'b0;
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_wrap_restart();
        bit ok;
        int k;
        sel = 1'b1; corrupt.delete(); clear_logs();
        pulse_start(1'b1);
        k = 0;
        while (!b_wr && k < 50) begin @(posedge clk); #1; k++; end
        pulse_start(1'b1);
        wait_done(1'b1, ok);
        n_checks++; if (!ok || b_pass !== 1'b1) begin n_errors++; $display("FAIL wrap_pass: got %b expected 1", b_pass); end
        n_checks++; if (log_addr.size() != 2) begin n_errors++; $display("FAIL wrap_nwr: got %0d expected 2", log_addr.size()); end
        for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
            n_checks++; if (log_addr[i] !== exp_addr(26'h3FFFFFC, i)) begin
                n_errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, log_addr[i], exp_addr(26'h3FFFFFC, i)); end
        end
        pulse_start(1'b1);
        n_checks++; if ({b_done, b_busy} !== 2'b01) begin
            n_errors++; $display("FAIL restart: got done/busy=%b expected 01", {b_done, b_busy}); end
        wait_done(1'b1, ok);
        n_checks++; if (!ok || b_pass !== 1'b1) begin n_errors++; $display("FAIL restart_pass: got %b expected 1", b_pass); end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int k;
        sel = 1'b0; corrupt.delete(); clear_logs();
        pulse_start(1'b0);
        k = 0;
        while (!a_rd && k < 2000) begin @(posedge clk); #1; k++; end
        n_checks++; if (a_rd !== 1'b1) begin n_errors++; $display("FAIL mid_rd: got %b expected 1", a_rd); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (a_all !== '0) begin n_errors++; $display("FAIL mid_async: got %h expected 0", a_all); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        pulse_start(1'b0);
        wait_done(1'b0, ok);
        n_checks++; if (log_addr.size() < 1 || log_addr[0] !== 26'h0 || log_data[0] !== pat(0)) begin
            n_errors++; $display("FAIL mid_rerun: got %0d writes, first not addr 0 / P(0)", log_addr.size()); end
        n_checks++; if (!ok || a_pass !== 1'b1) begin n_errors++; $display("FAIL mid_pass: got %b expected 1", a_pass); end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        sel = 1'b0; start_a = 1'b0; start_b = 1'b0; rst_n = 1'b0;
        test_reset();
        test_clean_pass();
        test_single_corrupt();
        test_random_corrupt();
        test_refresh();
        test_timeout();
        test_wrap_restart();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
